pkt_header_insert: RTL and testbench
====================================

Name: pkt_header_insert

Overview:
- Sits directly downstream of the TLAST generator, upstream of the AXI DMA S2MM port.
- Takes the 128-bit DDC sample stream with TLAST already framed and prepends one 128-bit header beat to every packet.
- The header carries a magic word, a sequence number, a timestamp and the packet length, so host software can detect lost or truncated packets.

Parameters:
- C_WIDTH, 32, width of packet_length and of the internal payload beat counter.
- C_MAGIC, 32'hDDC0FFEE, constant placed in header bits [31:0].
- C_TS_WIDTH, 48, width of the free-running timestamp counter; must be ≤48.

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_areset  in  1  reset; synchronous, active-high.
- enable  in  1  when low, no new packet is started; a packet in progress completes.
- packet_length  in  C_WIDTH  expected payload beats per packet; sampled at packet start.
- s_axis_tdata  in  128  payload in.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tready  out  1  payload ready.
- s_axis_tlast  in  1  last payload beat.
- m_axis_tdata  out  128  header or payload out.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the output packet.
- seq_num  out  32  sequence number of the most recently started packet.
- len_err  out  1  sticky length-mismatch flag; cleared only by reset.

Behaviour:
- Reset (synchronous, s_axis_areset=1):
  - state=IDLE; seq counter=0; timestamp=0; beat counter=0.
  - len_err=0; m_axis_tvalid=0; s_axis_tready=0; m_axis_tlast=0; m_axis_tdata=0.
- Timestamp:
  - Increments by 1 every cycle out of reset.
  - Wraps modulo 2^C_TS_WIDTH.
- FSM state IDLE:
  - s_axis_tready=0; m_axis_tvalid=0.
  - If enable & s_axis_tvalid:
    - latch header fields: seq counter, timestamp, packet_length[15:0];
    - go to HDR.
- FSM state HDR:
  - m_axis_tdata = {len[15:0], ts[47:0], seq[31:0], C_MAGIC}, all from registers.
  - m_axis_tvalid=1; m_axis_tlast=0; s_axis_tready=0.
  - On m_axis_tready: seq counter += 1 (wraps at 2^32), beat counter=0, go to PAY.
  - Header fields are stable while m_axis_tready=0.
- FSM state PAY (combinational pass-through):
  - m_axis_tdata=s_axis_tdata; m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready; m_axis_tlast=s_axis_tlast.
  - On each transfer (s_axis_tvalid & m_axis_tready), beat counter += 1.
  - On a transfer with s_axis_tlast:
    - if the beat count including this beat ≠ latched packet_length, set len_err;
    - go to IDLE.
  - No forced termination: the packet ends only on input TLAST.
- Latency:
  - Header appears on the cycle after IDLE sees a valid input.
  - Payload adds zero cycles.
  - Minimum overhead is 2 cycles per packet (IDLE + HDR).
- Boundary conditions:
  - packet_length=0: a packet still starts; any TLAST sets len_err.
  - enable falling during HDR or PAY: no effect until the return to IDLE.
  - enable low in IDLE: input stalled (tready=0), no data dropped.
  - packet_length changing mid-packet: ignored; the latched value is used.
  - Reset mid-packet: immediate return to IDLE. The partial packet is abandoned and no TLAST is emitted; the downstream DMA must be reset together with this block.
- seq_num output = the latched sequence value of the current/last header.

Optional Feature:
- Macro: PKT_HDR_TS_EN.
- Defined: timestamp counter present; header bits [111:64] carry the timestamp, zero-extended to 48 bits.
- Undefined: no timestamp counter is instantiated; header bits [111:64] = 0; all else unchanged.

Decomposition:
- Package pkt_hdr_pkg holds:
  - FSM state enum (IDLE, HDR, PAY);
  - header field offsets (MAGIC_LSB=0, SEQ_LSB=32, TS_LSB=64, LEN_LSB=112);
  - default magic constant.
- No sub-module; the timestamp is a single counter inline under the macro.

Test Plan:
- Reset, packet_length=4, enable=1, 4 input beats with TLAST on beat 4, tready=1 → 5 output beats; beat0 = {16'd4, ts, 32'd0, 32'hDDC0FFEE}; tlast on beat 5 only; len_err=0; seq_num=0.
- Three back-to-back packets → header seq fields 0, 1, 2; each header's timestamp is strictly greater than the previous one's.
- Backpressure: m_axis_tready toggles 1/0 during HDR and PAY → header held stable; no payload beat lost or duplicated; s_axis_tready mirrors m_axis_tready in PAY.
- packet_length=4, TLAST on beat 3 → packet ends after 3 payload beats; len_err=1 and stays 1 across the next correct packet.
- enable=0 with s_axis_tvalid=1 → s_axis_tready=0 and m_axis_tvalid=0 indefinitely; enable=1 → header emitted on the next cycle.
- Reset asserted mid-payload → next cycle: state IDLE, m_axis_tvalid=0, seq_num=0; a new packet then starts with seq 0.

Source files
------------

// File: rtl/pkt_hdr_pkg.sv
// Shared types and header layout for the packet header inserter.
// Holds the FSM state encoding, header field offsets and the default magic word.
// Optional timestamp field width is fixed at 48 bits in the header (PKT_HDR_TS_EN).
package pkt_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } hdr_state_t;

    // Bit offsets of each field inside the 128-bit header beat
    localparam int MAGIC_LSB = 0;
    localparam int SEQ_LSB   = 32;
    localparam int TS_LSB    = 64;
    localparam int LEN_LSB   = 112;

    localparam int MAGIC_W   = 32;
    localparam int SEQ_W     = 32;
    localparam int TS_W      = 48;
    localparam int LEN_W     = 16;

    localparam logic [31:0] MAGIC_DEFAULT = 32'hDDC0FFEE;

endpackage

// File: rtl/pkt_header_insert.sv
// Purpose: prepend one 128-bit header beat (magic, seq, timestamp, length) to every framed packet.
// Latency: header one cycle after IDLE sees valid input; payload passes through with zero added cycles.
// Backpressure: header held stable until m_axis_tready; in payload s_axis_tready follows m_axis_tready.
// Build option: define PKT_HDR_TS_EN to include the free-running timestamp counter (else header ts = 0).
module pkt_header_insert
    import pkt_hdr_pkg::*;
#(
    parameter int          C_WIDTH    = 32,
    parameter logic [31:0] C_MAGIC    = MAGIC_DEFAULT,
    parameter int          C_TS_WIDTH = 48
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_areset,
    input  logic               enable,
    input  logic [C_WIDTH-1:0] packet_length,
    input  logic [127:0]       s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    output logic [127:0]       m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic [31:0]        seq_num,
    output logic               len_err
);

    localparam logic [C_WIDTH-1:0] BEAT_ONE = {{(C_WIDTH-1){1'b0}}, 1'b1};

    hdr_state_t          state;
    logic [SEQ_W-1:0]    seq_cnt;
    logic [C_WIDTH-1:0]  beat_cnt;
    logic [C_WIDTH-1:0]  beat_nxt;
    logic [SEQ_W-1:0]    hdr_seq;
    logic [TS_W-1:0]     hdr_ts;
    logic [C_WIDTH-1:0]  hdr_len;
    logic [TS_W-1:0]     ts_now;
    logic [127:0]        hdr_word;

`ifdef PKT_HDR_TS_EN
    logic [C_TS_WIDTH-1:0] ts_cnt;

    // Free-running timestamp, wraps naturally at 2^C_TS_WIDTH
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + {{(C_TS_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign ts_now = TS_W'(ts_cnt);
`else
    assign ts_now = '0;
`endif

    assign beat_nxt = beat_cnt + BEAT_ONE;
    assign seq_num  = hdr_seq;

    // Header/payload sequencing; header fields are latched when a packet starts
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state    <= IDLE;
            seq_cnt  <= '0;
            beat_cnt <= '0;
            hdr_seq  <= '0;
            hdr_ts   <= '0;
            hdr_len  <= '0;
            len_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && s_axis_tvalid) begin
                        hdr_seq <= seq_cnt;
                        hdr_ts  <= ts_now;
                        hdr_len <= packet_length;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    if (m_axis_tready) begin
                        seq_cnt  <= seq_cnt + 32'd1;
                        beat_cnt <= '0;
                        state    <= PAY;
                    end
                end
                PAY: begin
                    if (s_axis_tvalid && m_axis_tready) begin
                        beat_cnt <= beat_nxt;
                        // Packet ends only on input TLAST; a count mismatch is flagged, never truncated
                        if (s_axis_tlast) begin
                            if (beat_nxt != hdr_len) begin
                                len_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Header beat assembled purely from latched registers so it holds under backpressure
    always_comb begin
        hdr_word = '0;
        hdr_word[MAGIC_LSB +: MAGIC_W] = C_MAGIC;
        hdr_word[SEQ_LSB   +: SEQ_W]   = hdr_seq;
        hdr_word[TS_LSB    +: TS_W]    = hdr_ts;
        hdr_word[LEN_LSB   +: LEN_W]   = hdr_len[LEN_W-1:0];
    end

    // Output mux: idle outputs zero, header from registers, payload is a straight wire
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        case (state)
            HDR: begin
                m_axis_tdata  = hdr_word;
                m_axis_tvalid = 1'b1;
            end
            PAY: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pkt_header_insert.sv
// Bench for pkt_header_insert: scoreboarded source/sink with optional random downstream stalls.
// Expected beats are queued as the source drives them and compared as the DUT emits them.
// Build with PKT_HDR_TS_EN to also check timestamp monotonicity instead of a zero ts field.
module tb_pkt_header_insert;

    typedef struct {
        logic         hdr;
        logic [127:0] dat;
        logic         last;
    } exp_t;

    logic         s_axis_aclk;
    logic         s_axis_areset;
    logic         enable;
    logic [31:0]  packet_length;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  seq_num;
    logic         len_err;

    exp_t         sb[$];
    int           n_cmp;
    int           n_err;
    logic [31:0]  exp_seq;
    logic         bp_en;
    logic         have_ts;
    logic [47:0]  last_ts;
    logic         prev_stall;
    logic [127:0] prev_dat;

    pkt_header_insert dut (
        .s_axis_aclk   (s_axis_aclk),
        .s_axis_areset (s_axis_areset),
        .enable        (enable),
        .packet_length (packet_length),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .seq_num       (seq_num),
        .len_err       (len_err)
    );

    initial s_axis_aclk = 1'b0;
    always #5 s_axis_aclk = ~s_axis_aclk;

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Downstream ready: always 1, or randomly stalled when bp_en is set
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge s_axis_aclk);
            #1;
            m_axis_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Sink: scoreboard compare, AXI hold check and ready mirroring in payload
    always @(negedge s_axis_aclk) begin
        exp_t        e;
        logic [127:0] masked;
        logic [47:0]  ts;
        if (s_axis_areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_eq("hold_vld", m_axis_tvalid, 1);
                chk_eq("hold_dat", m_axis_tdata, prev_dat);
            end
            if (s_axis_tvalid && sb.size() > 0 && !sb[0].hdr)
                chk_eq("rdy_mirror", s_axis_tready, m_axis_tready);
            if (m_axis_tvalid && m_axis_tready) begin
                chk_eq("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    if (e.hdr) begin
                        ts = m_axis_tdata[111:64];
                        masked = m_axis_tdata;
                        masked[111:64] = '0;
                        chk_eq("hdr", masked, e.dat);
`ifdef PKT_HDR_TS_EN
                        if (have_ts) chk_eq("ts_incr", (ts > last_ts), 1);
                        last_ts = ts;
                        have_ts = 1'b1;
`else
                        chk_eq("ts_zero", ts, 0);
`endif
                    end else begin
                        chk_eq("pay", m_axis_tdata, e.dat);
                    end
                    chk_eq("last", m_axis_tlast, e.last);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_dat   = m_axis_tdata;
        end
    end

    // Present one input beat and hold it until accepted
    task automatic drive_beat(input logic [127:0] dat, input logic last);
        logic hs;
        int   t;
        s_axis_tdata  = dat;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        t = 0;
        do begin
            @(negedge s_axis_aclk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge s_axis_aclk);
            #1;
            t++;
        end while (!hs && t < 200);
        if (!hs) chk_eq("hs_timeout", hs, 1);
        // Changing length mid-packet must not affect the latched value
        packet_length = $urandom;
    endtask

    // One packet: plen goes in the header, nbeats payload beats with TLAST on the final one
    task automatic send_pkt(input int plen, input int nbeats, input int stall, input logic drop_en);
        exp_t         e;
        logic [127:0] beats[$];
        logic [127:0] d;
        logic [15:0]  l16;
        l16   = 16'(plen);
        e.hdr = 1'b1;
        e.dat = {l16, 48'd0, exp_seq, 32'hDDC0FFEE};
        e.last = 1'b0;
        sb.push_back(e);
        exp_seq = exp_seq + 1;
        for (int b = 0; b < nbeats; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            d[127:120] = 8'(b);
            beats.push_back(d);
            e.hdr  = 1'b0;
            e.dat  = d;
            e.last = (b == nbeats - 1);
            sb.push_back(e);
        end
        packet_length = 32'(plen);
        if (stall > 0) begin
            enable        = 1'b0;
            s_axis_tdata  = beats[0];
            s_axis_tlast  = (nbeats == 1);
            s_axis_tvalid = 1'b1;
            for (int c = 0; c < stall; c++) begin
                @(negedge s_axis_aclk);
                chk_eq("en_lo_trdy", s_axis_tready, 0);
                chk_eq("en_lo_mvld", m_axis_tvalid, 0);
            end
            @(posedge s_axis_aclk);
            #1;
            enable = 1'b1;
            @(posedge s_axis_aclk);
            #1;
            chk_eq("hdr_next_cycle", m_axis_tvalid, 1);
        end
        for (int b = 0; b < nbeats; b++) begin
            drive_beat(beats[b], (b == nbeats - 1));
            if (drop_en && b == 0) enable = 1'b0;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        enable        = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge s_axis_aclk);
            t++;
        end
        #1;
        chk_eq("drained", sb.size(), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_seq = 0;
        bp_en = 1'b0;
        have_ts = 1'b0;
        last_ts = '0;
        prev_stall = 1'b0;
        prev_dat = '0;
        s_axis_areset = 1'b1;
        enable = 1'b1;
        packet_length = 32'd4;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;

        repeat (3) @(posedge s_axis_aclk);
        @(negedge s_axis_aclk);
        chk_eq("rst_mvld", m_axis_tvalid, 0);
        chk_eq("rst_trdy", s_axis_tready, 0);
        chk_eq("rst_tlast", m_axis_tlast, 0);
        chk_eq("rst_tdata", m_axis_tdata, 0);
        chk_eq("rst_len_err", len_err, 0);
        chk_eq("rst_seq", seq_num, 0);
        @(posedge s_axis_aclk);
        #1;
        s_axis_areset = 1'b0;

        // Basic packet: 4 beats, length 4
        send_pkt(4, 4, 0, 1'b0);
        drain();
        chk_eq("p1_len_err", len_err, 0);
        chk_eq("p1_seq_num", seq_num, 0);

        // Three back-to-back packets
        send_pkt(2, 2, 0, 1'b0);
        send_pkt(1, 1, 0, 1'b0);
        send_pkt(3, 3, 0, 1'b0);
        drain();
        chk_eq("b2b_seq_num", seq_num, 3);
        chk_eq("b2b_len_err", len_err, 0);

        // Downstream backpressure, with enable dropped mid-packet
        bp_en = 1'b1;
        send_pkt(5, 5, 0, 1'b0);
        send_pkt(6, 6, 0, 1'b1);
        drain();
        bp_en = 1'b0;
        #20;
        chk_eq("bp_len_err", len_err, 0);

        // Enable held low while input is valid
        send_pkt(3, 3, 8, 1'b0);
        drain();
        chk_eq("en_len_err", len_err, 0);

        // Early TLAST sets the sticky error
        send_pkt(4, 3, 0, 1'b0);
        drain();
        chk_eq("short_len_err", len_err, 1);
        send_pkt(4, 4, 0, 1'b0);
        drain();
        chk_eq("sticky_len_err", len_err, 1);

        // Reset in the middle of a payload
        send_pkt(4, 0, 0, 1'b0);
        s_axis_tvalid = 1'b1;
        packet_length = 32'd4;
        begin
            exp_t e;
            logic [127:0] d;
            for (int b = 0; b < 2; b++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                e.hdr = 1'b0;
                e.dat = d;
                e.last = 1'b0;
                sb.push_back(e);
                drive_beat(d, 1'b0);
            end
        end
        drain();
        s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
        s_axis_tvalid = 1'b1;
        s_axis_areset = 1'b1;
        @(posedge s_axis_aclk);
        #1;
        chk_eq("midrst_mvld", m_axis_tvalid, 0);
        chk_eq("midrst_trdy", s_axis_tready, 0);
        chk_eq("midrst_seq", seq_num, 0);
        chk_eq("midrst_len_err", len_err, 0);
        s_axis_tvalid = 1'b0;
        @(posedge s_axis_aclk);
        #1;
        s_axis_areset = 1'b0;
        exp_seq = 0;
        have_ts = 1'b0;

        // Zero-length packet after reset: starts with seq 0, any TLAST flags an error
        send_pkt(0, 1, 0, 1'b0);
        drain();
        chk_eq("zero_len_err", len_err, 1);
        chk_eq("post_rst_seq", seq_num, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time limit reached");
        $fatal(1);
    end

endmodule
